// File: rtl/alu_exec_ctrl_if.sv
// Issue/memory/ALU bus of the ALU execution controller.
// master = the surrounding core (or bench), slave = alu_exec_ctrl.
interface alu_exec_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_cb;
    logic [7:0]  instr_opcode;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [4:0]  alu_op;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [3:0]  alu_f;
    logic [15:0] alu_o;
    logic [3:0]  alu_fout;

    modport master (
        output instr_valid, instr_cb, instr_opcode, mem_rdata, mem_ack, alu_o, alu_fout,
        input  instr_ready, done, err, mem_req, mem_we, mem_addr, mem_wdata,
               alu_op, alu_x, alu_y, alu_f
    );

    modport slave (
        input  instr_valid, instr_cb, instr_opcode, mem_rdata, mem_ack, alu_o, alu_fout,
        output instr_ready, done, err, mem_req, mem_we, mem_addr, mem_wdata,
               alu_op, alu_x, alu_y, alu_f
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// SM83 ALU-class issue/writeback controller with register file; register op retires 2 cycles after accept.
// Accepts only in IDLE (instr_ready); memory operand stalls on mem_ack for the (HL) read and CB (HL) write.
module alu_exec_ctrl #(
    parameter logic [7:0] RESET_A = 8'h01,
    parameter logic [7:0] RESET_F = 8'hB0
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_ctrl_if.slave bus,
    input  logic           ld_valid,
    input  logic [2:0]     ld_sel,
    input  logic [7:0]     ld_data,
    input  logic [2:0]     rd_sel,
    output logic [7:0]     rd_data
);
    localparam logic [2:0] IDX_H  = 3'd4;
    localparam logic [2:0] IDX_L  = 3'd5;
    localparam logic [2:0] IDX_F  = 3'd6;
    localparam logic [2:0] IDX_A  = 3'd7;
    localparam logic [2:0] SRC_HL = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, MEM_RD, MEM_WR} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] regs     [8];
    logic [7:0] reg_view [8];
    logic       accept;
    logic       legal;
    logic [2:0] src;
    logic [4:0] op_code;
    logic       is_cb;
    logic       is_cp;
    logic       is_mem;
    logic [2:0] sel;
    logic       unused_alu_hi;

    assign src             = bus.instr_opcode[2:0];
    assign bus.instr_ready = (state == IDLE);
    assign accept          = bus.instr_valid && (state == IDLE);
    assign legal           = bus.instr_cb ? (bus.instr_opcode[7:6] == 2'b00)
                                          : (bus.instr_opcode[7:6] == 2'b10);
    assign rd_data         = regs[rd_sel];
    assign unused_alu_hi   = ^bus.alu_o[15:8];

    // Register file as seen at the accept edge: a same-edge load is forwarded into the operands.
    always_comb begin
        for (int i = 0; i < 8; i++) reg_view[i] = regs[i];
        if (ld_valid) reg_view[ld_sel] = (ld_sel == IDX_F) ? {ld_data[7:4], 4'h0} : ld_data;
    end

    always_comb begin
        op_code = 5'h00;
        if (bus.instr_cb) begin
            case (bus.instr_opcode[5:3])
                3'd0: op_code = 5'h08;
                3'd1: op_code = 5'h0A;
                3'd2: op_code = 5'h09;
                3'd3: op_code = 5'h0B;
                3'd4: op_code = 5'h0C;
                3'd5: op_code = 5'h0D;
                3'd6: op_code = 5'h0F;
                3'd7: op_code = 5'h0E;
                default: op_code = 5'h00;
            endcase
        end else begin
            case (bus.instr_opcode[5:3])
                3'd0: op_code = 5'h04;
                3'd1: op_code = 5'h05;
                3'd2: op_code = 5'h06;
                3'd3: op_code = 5'h07;
                3'd4: op_code = 5'h01;
                3'd5: op_code = 5'h02;
                3'd6: op_code = 5'h00;
                3'd7: op_code = 5'h06;
                default: op_code = 5'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && legal) state_nxt = (src == SRC_HL) ? MEM_RD : EXEC;
            MEM_RD:  if (bus.mem_ack) state_nxt = EXEC;
            EXEC:    state_nxt = (is_cb && is_mem) ? MEM_WR : IDLE;
            MEM_WR:  if (bus.mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            regs[IDX_A]   <= RESET_A;
            regs[IDX_F]   <= {RESET_F[7:4], 4'h0};
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 16'h0000;
            bus.mem_wdata <= 8'h00;
            bus.alu_op    <= 5'h00;
            bus.alu_x     <= 16'h0000;
            bus.alu_y     <= 16'h0000;
            bus.alu_f     <= 4'h0;
            is_cb         <= 1'b0;
            is_cp         <= 1'b0;
            is_mem        <= 1'b0;
            sel           <= 3'd0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_valid) regs[ld_sel] <= reg_view[ld_sel];
                    if (accept && !legal) begin
                        bus.err <= 1'b1;
                    end else if (accept) begin
                        is_cb        <= bus.instr_cb;
                        is_cp        <= !bus.instr_cb && (bus.instr_opcode[5:3] == 3'd7);
                        is_mem       <= (src == SRC_HL);
                        sel          <= src;
                        bus.alu_op   <= op_code;
                        bus.alu_f    <= reg_view[IDX_F][7:4];
                        bus.mem_addr <= {reg_view[IDX_H], reg_view[IDX_L]};
                        bus.alu_x    <= {8'h00, bus.instr_cb ? reg_view[src] : reg_view[IDX_A]};
                        bus.alu_y    <= {8'h00, bus.instr_cb ? 8'h00 : reg_view[src]};
                        if (src == SRC_HL) begin
                            bus.mem_req <= 1'b1;
                            bus.mem_we  <= 1'b0;
                        end
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (is_cb) bus.alu_x <= {8'h00, bus.mem_rdata};
                        else       bus.alu_y <= {8'h00, bus.mem_rdata};
                    end
                end
                EXEC: begin
                    regs[IDX_F] <= {bus.alu_fout, 4'h0};
                    if (is_cb && is_mem) begin
                        bus.mem_wdata <= bus.alu_o[7:0];
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                    end else begin
                        if (is_cb)       regs[sel]   <= bus.alu_o[7:0];
                        else if (!is_cp) regs[IDX_A] <= bus.alu_o[7:0];
                        bus.done <= 1'b1;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
